// File: rtl/maze_pkg.sv
// Shared key codes, state/winner encodings and the classic 10x10 layout
// for the capture-the-flag maze engine.
package maze_pkg;

    localparam logic [7:0] KEY_P1_UP    = 8'h75;
    localparam logic [7:0] KEY_P1_DOWN  = 8'h72;
    localparam logic [7:0] KEY_P1_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_P1_RIGHT = 8'h74;
    localparam logic [7:0] KEY_P2_UP    = 8'h1D;
    localparam logic [7:0] KEY_P2_DOWN  = 8'h1B;
    localparam logic [7:0] KEY_P2_LEFT  = 8'h1C;
    localparam logic [7:0] KEY_P2_RIGHT = 8'h23;
    localparam logic [7:0] KEY_START    = 8'h29;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_WIN  = 2'b10
    } game_state_e;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_e;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    // Rows are written as drawn (cell 0 leftmost); flip so that bit x = cell x.
    function automatic logic [9:0] row_from_text(input logic [9:0] drawn);
        logic [9:0] cells;
        cells = 10'd0;
        for (int x = 0; x < 10; x++) begin
            cells[x] = drawn[9 - x];
        end
        return cells;
    endfunction

    localparam logic [99:0] DEFAULT_MAZE_10 = {
        row_from_text(10'b0100010000),
        row_from_text(10'b0101010010),
        row_from_text(10'b0001000110),
        row_from_text(10'b1111110010),
        row_from_text(10'b0000000010),
        row_from_text(10'b0011101000),
        row_from_text(10'b1000101110),
        row_from_text(10'b1110101010),
        row_from_text(10'b0000100010),
        row_from_text(10'b0010101010)
    };

endpackage

// File: rtl/maze_game_engine_move_cooldown.sv
// Per-player move lockout: after an accepted move the player stays busy
// for MOVE_DIV-1 further cycles.
module move_cooldown #(
    parameter int MOVE_DIV = 6750000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic busy
);

    localparam int CNT_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(MOVE_DIV - 1);

    logic [CNT_W-1:0] r_count;

    // Reload on accept, otherwise count down to zero and hold.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= CNT_W'(0);
        end else if (load) begin
            r_count <= RELOAD;
        end else if (r_count != CNT_W'(0)) begin
            r_count <= r_count - CNT_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign busy = (r_count != CNT_W'(0));

endmodule

// File: rtl/maze_game_engine.sv
// Two-player capture-the-flag engine: maze store, player positions,
// move validation with cooldown, and the IDLE/PLAY/WIN game FSM.
module maze_game_engine
    import maze_pkg::*;
#(
    parameter int              N         = 10,
    parameter int              CW        = 4,
    parameter int              MOVE_DIV  = 6750000,
    parameter int              SCORE_W   = 4,
    parameter logic [N*N-1:0]  MAZE_INIT = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         key_code,
    input  logic               key_valid,
    input  logic               maze_we,
    input  logic [CW-1:0]      maze_waddr,
    input  logic [N-1:0]       maze_wdata,
    input  logic [CW-1:0]      row_sel,
    output logic [N-1:0]       row_data,
    output logic [CW-1:0]      p1_x,
    output logic [CW-1:0]      p1_y,
    output logic [CW-1:0]      p2_x,
    output logic [CW-1:0]      p2_y,
    output logic [1:0]         game_state,
    output logic [1:0]         winner,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [1:0]         move_ack
);

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [N-1:0]       r_maze [N];
    logic [CW-1:0]      r_p1_x, r_p1_y, r_p2_x, r_p2_y;
    game_state_e        r_state;
    logic [1:0]         r_winner;
    logic [SCORE_W-1:0] r_score1, r_score2;
    logic [1:0]         r_move_ack;

    dir_e          w_dir;
    logic          w_is_p2, w_start;
    logic [CW-1:0] w_cur_x, w_cur_y, w_oth_x, w_oth_y, w_tgt_x, w_tgt_y;
    logic          w_in_grid, w_wall, w_occupied, w_busy_sel, w_accept, w_capture;
    logic [N-1:0]  w_tgt_row;
    logic          w_busy1, w_busy2, w_load1, w_load2;

    // Decode the scan code into a mover, a direction, or a start request.
    always_comb begin
        w_dir   = DIR_NONE;
        w_is_p2 = 1'b0;
        w_start = 1'b0;
        if (key_valid) begin
            case (key_code)
                KEY_P1_UP:    w_dir = DIR_UP;
                KEY_P1_DOWN:  w_dir = DIR_DOWN;
                KEY_P1_LEFT:  w_dir = DIR_LEFT;
                KEY_P1_RIGHT: w_dir = DIR_RIGHT;
                KEY_P2_UP:    begin w_dir = DIR_UP;    w_is_p2 = 1'b1; end
                KEY_P2_DOWN:  begin w_dir = DIR_DOWN;  w_is_p2 = 1'b1; end
                KEY_P2_LEFT:  begin w_dir = DIR_LEFT;  w_is_p2 = 1'b1; end
                KEY_P2_RIGHT: begin w_dir = DIR_RIGHT; w_is_p2 = 1'b1; end
                KEY_START:    w_start = 1'b1;
                default:      w_dir = DIR_NONE;
            endcase
        end else begin
            w_start = 1'b0;
        end
    end

    // Target cell of the requested move; edges never wrap.
    always_comb begin
        w_cur_x   = w_is_p2 ? r_p2_x : r_p1_x;
        w_cur_y   = w_is_p2 ? r_p2_y : r_p1_y;
        w_oth_x   = w_is_p2 ? r_p1_x : r_p2_x;
        w_oth_y   = w_is_p2 ? r_p1_y : r_p2_y;
        w_tgt_x   = w_cur_x;
        w_tgt_y   = w_cur_y;
        w_in_grid = 1'b0;
        case (w_dir)
            DIR_UP:    begin w_in_grid = (w_cur_y != CW'(0)); w_tgt_y = w_cur_y - CW'(1); end
            DIR_DOWN:  begin w_in_grid = (w_cur_y != LAST);   w_tgt_y = w_cur_y + CW'(1); end
            DIR_LEFT:  begin w_in_grid = (w_cur_x != CW'(0)); w_tgt_x = w_cur_x - CW'(1); end
            DIR_RIGHT: begin w_in_grid = (w_cur_x != LAST);   w_tgt_x = w_cur_x + CW'(1); end
            default:   w_in_grid = 1'b0;
        endcase
    end

    // Wall bit of the target cell and the renderer's row read.
    always_comb begin
        w_tgt_row = {N{1'b0}};
        w_wall    = 1'b0;
        row_data  = {N{1'b0}};
        for (int y = 0; y < N; y++) begin
            w_tgt_row = (w_tgt_y == CW'(y)) ? r_maze[y] : w_tgt_row;
            row_data  = (row_sel == CW'(y)) ? r_maze[y] : row_data;
        end
        for (int x = 0; x < N; x++) begin
            w_wall = (w_tgt_x == CW'(x)) ? w_tgt_row[x] : w_wall;
        end
    end

    assign w_occupied = (w_tgt_x == w_oth_x) && (w_tgt_y == w_oth_y);
    assign w_busy_sel = w_is_p2 ? w_busy2 : w_busy1;
    assign w_accept   = (r_state == ST_PLAY) && (w_dir != DIR_NONE) && w_in_grid &&
                        !w_wall && !w_occupied && !w_busy_sel;
    assign w_capture  = w_is_p2 ? ((w_tgt_x == CW'(0)) && (w_tgt_y == CW'(0)))
                                : ((w_tgt_x == LAST) && (w_tgt_y == LAST));
    assign w_load1    = w_accept && !w_is_p2;
    assign w_load2    = w_accept && w_is_p2;

    move_cooldown #(.MOVE_DIV(MOVE_DIV)) u_cd_p1 (
        .clk(clk), .reset(reset), .load(w_load1), .busy(w_busy1)
    );
    move_cooldown #(.MOVE_DIV(MOVE_DIV)) u_cd_p2 (
        .clk(clk), .reset(reset), .load(w_load2), .busy(w_busy2)
    );

    // Game FSM with maze store, positions, scores and move acknowledge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int y = 0; y < N; y++) begin
                r_maze[y] <= MAZE_INIT[y*N +: N];
            end
            r_p1_x     <= CW'(0);
            r_p1_y     <= CW'(0);
            r_p2_x     <= LAST;
            r_p2_y     <= LAST;
            r_state    <= ST_IDLE;
            r_winner   <= WIN_NONE;
            r_score1   <= SCORE_W'(0);
            r_score2   <= SCORE_W'(0);
            r_move_ack <= 2'b00;
        end else begin
            r_move_ack <= 2'b00;
            case (r_state)
                ST_IDLE: begin
                    for (int y = 0; y < N; y++) begin
                        if (maze_we && (maze_waddr == CW'(y))) begin
                            r_maze[y] <= maze_wdata;
                        end
                    end
                    if (w_start) begin
                        r_state <= ST_PLAY;
                        r_p1_x  <= CW'(0);
                        r_p1_y  <= CW'(0);
                        r_p2_x  <= LAST;
                        r_p2_y  <= LAST;
                    end
                end
                ST_PLAY: begin
                    if (w_accept) begin
                        if (w_is_p2) begin
                            r_p2_x     <= w_tgt_x;
                            r_p2_y     <= w_tgt_y;
                            r_move_ack <= 2'b10;
                        end else begin
                            r_p1_x     <= w_tgt_x;
                            r_p1_y     <= w_tgt_y;
                            r_move_ack <= 2'b01;
                        end
                        if (w_capture) begin
                            r_state <= ST_WIN;
                            if (w_is_p2) begin
                                r_winner <= WIN_P2;
                                r_score2 <= (&r_score2) ? r_score2 : r_score2 + SCORE_W'(1);
                            end else begin
                                r_winner <= WIN_P1;
                                r_score1 <= (&r_score1) ? r_score1 : r_score1 + SCORE_W'(1);
                            end
                        end
                    end
                end
                ST_WIN: begin
                    if (w_start) begin
                        r_state  <= ST_PLAY;
                        r_winner <= WIN_NONE;
                        r_p1_x   <= CW'(0);
                        r_p1_y   <= CW'(0);
                        r_p2_x   <= LAST;
                        r_p2_y   <= LAST;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign p1_x       = r_p1_x;
    assign p1_y       = r_p1_y;
    assign p2_x       = r_p2_x;
    assign p2_y       = r_p2_y;
    assign game_state = r_state;
    assign winner     = r_winner;
    assign score1     = r_score1;
    assign score2     = r_score2;
    assign move_ack   = r_move_ack;

endmodule

// File: tb/tb_maze_game_engine.sv
// Directed plus randomized bench for maze_game_engine, checked every cycle
// against a cell/cycle-level reference model of the game rules.
module tb_maze_game_engine;
    import maze_pkg::*;

    localparam int N = 10, CW = 4, MD = 4, SW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    key_code = 8'h00;
    logic          key_valid = 1'b0, maze_we = 1'b0;
    logic [CW-1:0] maze_waddr = 4'd0, row_sel = 4'd0;
    logic [N-1:0]  maze_wdata = 10'd0, row_data;
    logic [CW-1:0] p1_x, p1_y, p2_x, p2_y;
    logic [1:0]    game_state, winner, move_ack;
    logic [SW-1:0] score1, score2;

    maze_game_engine #(.N(N), .CW(CW), .MOVE_DIV(MD), .SCORE_W(SW),
                       .MAZE_INIT(DEFAULT_MAZE_10)) dut (
        .clk(clk), .reset(reset), .key_code(key_code), .key_valid(key_valid),
        .maze_we(maze_we), .maze_waddr(maze_waddr), .maze_wdata(maze_wdata),
        .row_sel(row_sel), .row_data(row_data),
        .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
        .game_state(game_state), .winner(winner), .score1(score1), .score2(score2),
        .move_ack(move_ack)
    );

    always #5 clk = ~clk;

    int n_assert = 0, n_fail = 0;
    int rs = 0;
    int cyc = 0;

    // Reference model: maze as drawn text, positions as integer coordinates,
    // cooldown as "earliest cycle a player may move again".
    string layout [10] = '{"0010101010", "0000100010", "1110101010", "1000101110",
                           "0011101000", "0000000010", "1111110010", "0001000110",
                           "0101010010", "0100010000"};
    logic [9:0] m_maze [10];
    int m_px [2], m_py [2], m_next_ok [2];
    int m_state, m_winner, m_score [2];
    logic [1:0] m_ack;

    task automatic model_home();
        m_px[0] = 0;     m_py[0] = 0;
        m_px[1] = N - 1; m_py[1] = N - 1;
    endtask

    task automatic model_reset();
        for (int y = 0; y < N; y++)
            for (int x = 0; x < N; x++)
                m_maze[y][x] = (layout[y][x] == 8'h31);
        model_home();
        m_next_ok[0] = 0; m_next_ok[1] = 0;
        m_state = 0; m_winner = 0; m_score[0] = 0; m_score[1] = 0; m_ack = 2'b00;
    endtask

    task automatic model_edge(input logic [7:0] k, input logic kv, input logic we,
                              input int wa, input logic [9:0] wd, input logic rst);
        int pre, p, dx, dy, tx, ty;
        if (!rst) begin
            model_reset();
        end else begin
            pre = m_state; m_ack = 2'b00; p = -1; dx = 0; dy = 0;
            if (we && pre == 0 && wa < N) m_maze[wa] = wd;
            if (kv && k == 8'h29) begin
                if (pre != 1) begin m_state = 1; m_winner = 0; model_home(); end
            end else if (kv && pre == 1) begin
                case (k)
                    8'h75: begin p = 0; dy = -1; end
                    8'h72: begin p = 0; dy = 1;  end
                    8'h6B: begin p = 0; dx = -1; end
                    8'h74: begin p = 0; dx = 1;  end
                    8'h1D: begin p = 1; dy = -1; end
                    8'h1B: begin p = 1; dy = 1;  end
                    8'h1C: begin p = 1; dx = -1; end
                    8'h23: begin p = 1; dx = 1;  end
                    default: p = -1;
                endcase
                if (p >= 0) begin
                    tx = m_px[p] + dx; ty = m_py[p] + dy;
                    if (cyc >= m_next_ok[p] && tx >= 0 && tx < N && ty >= 0 && ty < N &&
                        m_maze[ty][tx] == 1'b0 && !(tx == m_px[1-p] && ty == m_py[1-p])) begin
                        m_px[p] = tx; m_py[p] = ty;
                        m_ack[p] = 1'b1;
                        m_next_ok[p] = cyc + MD;
                        if ((p == 0 && tx == N-1 && ty == N-1) || (p == 1 && tx == 0 && ty == 0)) begin
                            m_state = 2; m_winner = p + 1;
                            if (m_score[p] < 15) m_score[p] = m_score[p] + 1;
                        end
                    end
                end
            end
        end
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all();
        chk("game_state", 16'(game_state), 16'(m_state));
        chk("winner", 16'(winner), 16'(m_winner));
        chk("score1", 16'(score1), 16'(m_score[0]));
        chk("score2", 16'(score2), 16'(m_score[1]));
        chk("p1_x", 16'(p1_x), 16'(m_px[0]));
        chk("p1_y", 16'(p1_y), 16'(m_py[0]));
        chk("p2_x", 16'(p2_x), 16'(m_px[1]));
        chk("p2_y", 16'(p2_y), 16'(m_py[1]));
        chk("move_ack", 16'(move_ack), 16'(m_ack));
        chk("row_data", 16'(row_data), (rs < N) ? 16'(m_maze[rs]) : 16'd0);
    endtask

    task automatic step(input logic [7:0] k, input logic kv, input logic we,
                        input int wa, input logic [9:0] wd);
        @(negedge clk);
        key_code = k; key_valid = kv; maze_we = we;
        maze_waddr = wa[3:0]; maze_wdata = wd; row_sel = rs[3:0];
        @(posedge clk);
        model_edge(k, kv, we, wa, wd, reset);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(8'h00, 1'b0, 1'b0, 0, 10'd0);
    endtask

    task automatic press(input logic [7:0] k);
        step(k, 1'b1, 1'b0, 0, 10'd0);
    endtask

    // Press a key n times, leaving the cooldown just long enough to expire.
    task automatic mv(input logic [7:0] k, input int n);
        for (int i = 0; i < n; i++) begin
            press(k);
            idle(MD - 1);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; idle(1); reset = 1'b1;
    endtask

    task automatic clear_maze();
        for (int y = 0; y < N; y++) step(8'h00, 1'b0, 1'b1, y, 10'd0);
    endtask

    task automatic p1_win_run();
        mv(8'h1C, 1);
        mv(8'h74, N - 1);
        mv(8'h72, N - 1);
    endtask

    initial begin
        int codes [11] = '{32'h75, 32'h72, 32'h6B, 32'h74, 32'h1D, 32'h1B,
                           32'h1C, 32'h23, 32'h29, 32'h5A, 32'h00};
        logic [7:0] k;

        // Reset state, then start.
        reset = 1'b0; idle(2);
        chk("rst_state", 16'(game_state), 16'd0);
        chk("rst_p2x", 16'(p2_x), 16'd9);
        reset = 1'b1;
        press(8'h29);
        chk("start_state", 16'(game_state), 16'd1);

        // Corner boundaries: no move, no ack.
        press(8'h75); press(8'h6B); press(8'h1B); press(8'h23);
        chk("edge_p1", 16'({p1_x, p1_y}), 16'h00);
        chk("edge_p2", 16'({p2_x, p2_y}), 16'h99);
        chk("edge_ack", 16'(move_ack), 16'd0);

        // Accepted move, cooldown drop, then wall reject.
        press(8'h74);
        chk("mv_p1x", 16'(p1_x), 16'd1);
        chk("mv_ack", 16'(move_ack), 16'd1);
        idle(1); press(8'h74);
        chk("cd_p1x", 16'(p1_x), 16'd1);
        idle(1); press(8'h74);
        chk("wall_p1x", 16'(p1_x), 16'd1);
        chk("wall_ack", 16'(move_ack), 16'd0);

        // Maze write honoured in IDLE only.
        do_reset();
        rs = 3;
        step(8'h00, 1'b0, 1'b1, 3, 10'd0);
        chk("wr_idle", 16'(row_data), 16'd0);
        press(8'h29);
        step(8'h00, 1'b0, 1'b1, 3, 10'h3FF);
        chk("wr_play", 16'(row_data), 16'd0);

        // Capture on an open maze, restart keeps the score.
        do_reset(); clear_maze(); press(8'h29);
        p1_win_run();
        chk("win_state", 16'(game_state), 16'd2);
        chk("win_who", 16'(winner), 16'd1);
        chk("win_s1", 16'(score1), 16'd1);
        press(8'h74);
        press(8'h29);
        chk("restart_p1", 16'({p1_x, p1_y}), 16'h00);
        chk("restart_s1", 16'(score1), 16'd1);
        for (int i = 0; i < 2; i++) begin p1_win_run(); press(8'h29); end
        chk("s1_three", 16'(score1), 16'd3);

        // Reset mid-game.
        rs = 0;
        do_reset();
        chk("mid_rst_state", 16'(game_state), 16'd0);
        chk("mid_rst_s1", 16'(score1), 16'd0);

        // P2 capture and P1 score saturation.
        clear_maze(); press(8'h29);
        mv(8'h72, 1); mv(8'h1D, N - 1); mv(8'h1C, N - 1);
        chk("p2_win", 16'(winner), 16'd2);
        for (int i = 0; i < 16; i++) begin press(8'h29); p1_win_run(); end
        chk("s1_sat", 16'(score1), 16'd15);
        chk("s2_kept", 16'(score2), 16'd1);

        // Randomized play on a sparse random maze.
        do_reset();
        for (int y = 0; y < N; y++)
            step(8'h00, 1'b0, 1'b1, y, 10'($urandom & $urandom & $urandom));
        press(8'h29);
        for (int i = 0; i < 1500; i++) begin
            rs = $urandom_range(0, 15);
            k = 8'(codes[$urandom_range(0, 10)]);
            if (k == 8'h29 && $urandom_range(0, 3) != 0) k = 8'h74;
            reset = ($urandom_range(0, 299) != 0);
            step(k, ($urandom_range(0, 9) < 7), ($urandom_range(0, 7) == 0),
                 $urandom_range(0, 15), 10'($urandom & $urandom));
            reset = 1'b1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
